// File: rtl/store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer: pipeline widths, the
// store opcode that drives MEM_wmem, the buffered entry layout and drain states.
package store_buffer_pkg;

    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    // Opcode the control unit decodes to assert MEM_wmem.
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE,
        SB_DRAIN
    } sb_state_t;

endpackage

// File: rtl/store_buffer_sb_match.sv
// Youngest-match selector for store-to-load bypass: walks the live entries
// from head to tail so the last hit seen is the youngest one.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [PW-1:0]    head,
    input  logic [SB_AW-1:0] ld_addr,
    output logic             hit,
    output logic [SB_DW-1:0] data
);

    logic [PW-1:0] idx;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (entries[idx].addr == ld_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between EXE_MEM outputs and the data memory write port:
// circular FIFO, registered drain FSM with req/gnt, and load bypass.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    output logic          st_err,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          empty
);

    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_next;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_next;
    sb_state_t        state;

    logic enq;
    logic deq;
    logic misaligned;
    logic match_hit;
    logic [SB_DW-1:0] match_data;

    assign st_ready   = (count < CW'(DEPTH)) && !flush;
    assign enq        = st_valid && st_ready && (st_addr[1:0] == 2'b00);
    assign misaligned = st_valid && st_ready && (st_addr[1:0] != 2'b00);
    // mem_req is only high with count>0, so a dequeue can never underflow.
    assign deq        = mem_req && mem_gnt;
    assign empty      = (count == '0);

    assign mem_addr   = AW'(entries[head].addr);
    assign mem_wdata  = DW'(entries[head].data);

    always_comb begin
        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Head is only cleared on dequeue and tail only set on enqueue; they never
    // coincide when both happen, since that needs 0 < count < DEPTH.
    always_comb begin
        valid_next = valid;
        if (deq) valid_next[head] = 1'b0;
        if (enq) valid_next[tail] = 1'b1;
    end

    // NOTE: the entry array has no reset; the valid mask alone decides what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{addr: SB_AW'(st_addr), data: SB_DW'(st_data)};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid   <= '0;
            st_err  <= 1'b0;
            mem_req <= 1'b0;
            state   <= SB_IDLE;
        end else begin
            st_err <= misaligned;
            count  <= count_next;
            valid  <= valid_next;
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);

            case (state)
                SB_IDLE: begin
                    if (count_next != '0) begin
                        state   <= SB_DRAIN;
                        mem_req <= 1'b1;
                    end
                end
                SB_DRAIN: begin
                    if (count_next == '0) begin
                        state   <= SB_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= SB_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    sb_match #(.DEPTH(DEPTH)) u_match (
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .ld_addr (SB_AW'(ld_addr)),
        .hit     (match_hit),
        .data    (match_data)
    );

    assign ld_hit  = match_hit;
    assign ld_data = DW'(match_data);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected memory writes go into a queue
// as stores are issued; a monitor pops and compares on every granted write.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_err;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        flush;
    logic [2:0]  count;
    logic        empty;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .st_err    (st_err),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .flush     (flush),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        int n;
        exp_q.push_back('{a: a, d: d});
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        n = 0;
        while (!st_ready && n < 50) begin
            step();
            n++;
        end
        if (!st_ready) check("store_accept_timeout", 64'd0, 64'd1);
        step();
        st_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!empty && n < 100) begin
            step();
            n++;
        end
        check(name, {63'd0, empty}, 64'd1);
    endtask

    // A write happens at the next rising edge whenever req and gnt are both high here.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst && mem_req && mem_gnt) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    miscompares++;
                    $display("FAIL write_order: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = '0; mem_gnt = 1'b0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);
        check("reset_mem_req", mem_req, 0);
        check("reset_st_err", st_err, 0);
        check("reset_st_ready", st_ready, 1);

        // Reset mid-drain: pending writes are abandoned.
        store(32'h0, 32'hA0A0_0000);
        store(32'h4, 32'hA0A0_0004);
        store(32'h8, 32'hA0A0_0008);
        check("middrain_count", count, 3);
        check("middrain_req", mem_req, 1);
        check("middrain_head_addr", mem_addr, 32'h0);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        check("postrst_count", count, 0);
        check("postrst_req", mem_req, 0);
        check("postrst_empty", empty, 1);
        mem_gnt = 1'b1;
        step();
        step();
        step();
        check("postrst_no_write", mem_req, 0);

        // Basic drain with gnt held high.
        store(32'h10, 32'h4000_0044);
        check("basic_req", mem_req, 1);
        check("basic_addr", mem_addr, 32'h10);
        check("basic_wdata", mem_wdata, 32'h4000_0044);
        check("basic_count1", count, 1);
        step();
        check("basic_count0", count, 0);
        check("basic_req_off", mem_req, 0);

        // Full and back-pressure.
        mem_gnt = 1'b0;
        store(32'h0, 32'hB000_0000);
        store(32'h4, 32'hB000_0004);
        store(32'h8, 32'hB000_0008);
        store(32'hC, 32'hB000_000C);
        check("full_count", count, 4);
        check("full_ready", st_ready, 0);
        exp_q.push_back('{a: 32'h20, d: 32'hDEAD_BEEF});
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'hDEAD_BEEF;
        step();
        step();
        check("full_held_count", count, 4);
        mem_gnt = 1'b1;
        begin
            int n;
            n = 0;
            while (!st_ready && n < 20) begin
                step();
                n++;
            end
            check("full_ready_again", st_ready, 1);
            check("full_count_after_one", count, 3);
        end
        step();
        st_valid = 1'b0;
        check("full_fifth_taken_count", count, 3);
        wait_empty("full_drain_empty");

        // Bypass youngest match.
        mem_gnt = 1'b0;
        exp_q.push_back('{a: 32'h8, d: 32'h1111_1111});
        st_valid = 1'b1; st_addr = 32'h8; st_data = 32'h1111_1111; ld_addr = 32'h8;
        #1;
        check("bypass_same_cycle_hit", ld_hit, 0);
        step();
        st_valid = 1'b0;
        check("bypass_one_hit", ld_hit, 1);
        check("bypass_one_data", ld_data, 32'h1111_1111);
        store(32'h8, 32'h2222_2222);
        check("bypass_young_hit", ld_hit, 1);
        check("bypass_young_data", ld_data, 32'h2222_2222);
        ld_addr = 32'hC;
        #1;
        check("bypass_miss_hit", ld_hit, 0);
        check("bypass_miss_data", ld_data, 0);
        mem_gnt = 1'b1;
        wait_empty("bypass_drain_empty");
        ld_addr = 32'h8;
        #1;
        check("bypass_after_drain", ld_hit, 0);

        // Simultaneous enqueue and dequeue.
        mem_gnt = 1'b0;
        store(32'h100, 32'h0000_0001);
        store(32'h104, 32'h0000_0002);
        check("simul_count_before", count, 2);
        exp_q.push_back('{a: 32'h108, d: 32'h0000_0003});
        st_valid = 1'b1; st_addr = 32'h108; st_data = 32'h0000_0003;
        mem_gnt = 1'b1;
        step();
        st_valid = 1'b0;
        check("simul_count_after", count, 2);
        wait_empty("simul_drain_empty");

        // Misaligned store, then flush.
        mem_gnt = 1'b0;
        st_valid = 1'b1; st_addr = 32'h6; st_data = 32'h55;
        step();
        st_valid = 1'b0;
        check("misalign_err", st_err, 1);
        check("misalign_count", count, 0);
        step();
        check("misalign_err_pulse", st_err, 0);
        store(32'h200, 32'hC000_0200);
        store(32'h204, 32'hC000_0204);
        store(32'h208, 32'hC000_0208);
        check("flush_count", count, 3);
        flush = 1'b1;
        exp_q.push_back('{a: 32'h300, d: 32'hC000_0300});
        st_valid = 1'b1; st_addr = 32'h300; st_data = 32'hC000_0300;
        #1;
        check("flush_ready_low", st_ready, 0);
        mem_gnt = 1'b1;
        begin
            int n;
            n = 0;
            while (!empty && n < 50) begin
                check("flush_hold_ready", st_ready, 0);
                step();
                n++;
            end
        end
        check("flush_empty", empty, 1);
        flush = 1'b0;
        #1;
        check("flush_release_ready", st_ready, 1);
        step();
        st_valid = 1'b0;
        check("flush_post_count", count, 1);
        wait_empty("flush_final_drain");

        step();
        step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
